// File: rtl/ifra_arb.sv
// ifra_arb: round-robin arbiter sharing one downstream req/ack slave
// between NUM_REQ upstream req/ack masters. The winner's data is registered,
// forwarded downstream, and the winner is acked once the sink has acked.
// Optional feature macro: IFRA_ARB_TIMEOUT_EN (downstream ack timeout with
// sticky timeout_err). Without it, FWD waits indefinitely and timeout_err=0.
module ifra_arb #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int TIMEOUT_CYC = 255,
    localparam int IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            s_req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] s_din,
    output logic [NUM_REQ-1:0]            s_ack,
    output logic                          m_req,
    output logic [DATA_WIDTH-1:0]         m_dout,
    input  logic                          m_ack,
    output logic [IDW-1:0]                grant_id,
    output logic                          busy,
    output logic                          timeout_err
);

    typedef enum logic [1:0] {IDLE, FWD, ACK} state_e;

    state_e                  state_q;
    logic [NUM_REQ-1:0]      s_ack_q;
    logic                    m_req_q;
    logic [DATA_WIDTH-1:0]   m_dout_q;
    logic [IDW-1:0]          gid_q;
    logic                    busy_q;
    logic [IDW-1:0]          rr_q;
    logic [IDW-1:0]          sel_d;
    logic [IDW-1:0]          rr_d;
    int                      j;

`ifdef IFRA_ARB_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYC + 1);
    logic [TCW-1:0]          tcnt_q;
    logic                    tout_q;
`endif

    // First requester at or above the rr pointer, wrapping modulo NUM_REQ;
    // searching from the highest offset down leaves the lowest offset winning.
    always_comb begin
        sel_d = rr_q;
        j     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = int'(rr_q) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (s_req[j]) sel_d = IDW'(j);
        end
    end

    // The port just served drops to lowest priority.
    always_comb begin
        rr_d = (gid_q == IDW'(NUM_REQ - 1)) ? '0 : gid_q + 1'b1;
    end

    // Arbitration FSM; every output comes straight from a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            s_ack_q  <= '0;
            m_req_q  <= 1'b0;
            m_dout_q <= '0;
            gid_q    <= '0;
            busy_q   <= 1'b0;
            rr_q     <= '0;
`ifdef IFRA_ARB_TIMEOUT_EN
            tcnt_q   <= '0;
            tout_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    // A lingering m_ack from the previous transfer blocks a new grant.
                    if (|s_req && !m_ack) begin
                        gid_q    <= sel_d;
                        m_dout_q <= s_din[int'(sel_d)*DATA_WIDTH +: DATA_WIDTH];
                        m_req_q  <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= FWD;
`ifdef IFRA_ARB_TIMEOUT_EN
                        tcnt_q   <= '0;
`endif
                    end
                end
                FWD: begin
                    // Upstream data is not re-sampled here; m_dout stays as captured.
                    if (m_ack) begin
                        m_req_q  <= 1'b0;
                        m_dout_q <= '0;
                        s_ack_q  <= NUM_REQ'(1) << gid_q;
                        state_q  <= ACK;
                    end
`ifdef IFRA_ARB_TIMEOUT_EN
                    else if (tcnt_q == TCW'(TIMEOUT_CYC - 1)) begin
                        // Release the requester so a dead sink cannot hang it.
                        m_req_q  <= 1'b0;
                        m_dout_q <= '0;
                        tout_q   <= 1'b1;
                        s_ack_q  <= NUM_REQ'(1) << gid_q;
                        state_q  <= ACK;
                    end else begin
                        tcnt_q   <= tcnt_q + 1'b1;
                    end
`endif
                end
                ACK: begin
                    // Hold ack until the winner drops its request.
                    if (!s_req[gid_q]) begin
                        s_ack_q <= '0;
                        rr_q    <= rr_d;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign s_ack    = s_ack_q;
    assign m_req    = m_req_q;
    assign m_dout   = m_dout_q;
    assign grant_id = gid_q;
    assign busy     = busy_q;
`ifdef IFRA_ARB_TIMEOUT_EN
    assign timeout_err = tout_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: doc/ifra_arb.md
Name: ifra_arb

Overview:
- Round-robin arbiter/sequencer sharing one downstream req/ack slave between NUM_REQ upstream req/ack masters.
- Each upstream port uses the same level req/ack handshake as the team's req/ack master BFM: the master holds req and data until it sees ack, then drops req.
- The block registers the winner's data, forwards one transfer downstream, and returns ack to the winner.
- It sits between multiple traffic sources (BFM instances or RTL masters) and a single req/ack sink.

Parameters:
- NUM_REQ, 4, number of upstream requesters (2..16).
- DATA_WIDTH, 8, payload width.
- TIMEOUT_CYC, 255, downstream ack timeout in cycles. Used only with IFRA_ARB_TIMEOUT_EN.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- s_req  input  NUM_REQ  per-requester request level.
- s_din  input  NUM_REQ*DATA_WIDTH  per-requester data, flattened; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_ack  output  NUM_REQ  per-requester acknowledge, one-hot or zero.
- m_req  output  1  downstream request.
- m_dout  output  DATA_WIDTH  downstream data.
- m_ack  input  1  downstream acknowledge level.
- grant_id  output  $clog2(NUM_REQ)  index of current or last grantee.
- busy  output  1  high in any state other than IDLE.
- timeout_err  output  1  sticky timeout flag (IFRA_ARB_TIMEOUT_EN only, else tied 0).

Behaviour:
- Reset (async, rst_n=0): state=IDLE, s_ack=0, m_req=0, m_dout=0, grant_id=0, busy=0, timeout_err=0, rr pointer=0. All outputs are registered.
- FSM states: IDLE, FWD, ACK.
- IDLE:
  - Acts when any s_req bit is high and m_ack==0.
  - Selects the first set bit searching upward from rr pointer, wrapping modulo NUM_REQ.
  - Next edge: grant_id<=g, m_dout<=s_din[g], m_req<=1, state->FWD.
  - If m_ack is still high from the prior transfer, no grant is made.
- FWD:
  - m_req and m_dout are held stable.
  - On an edge with m_ack==1: m_req<=0, m_dout<=0, s_ack[g]<=1, state->ACK.
  - s_din is not re-sampled; changes on the upstream data after grant are ignored.
- ACK:
  - s_ack[g] is held high until an edge samples s_req[g]==0.
  - On that edge: s_ack<=0, rr pointer<=(g+1) mod NUM_REQ, state->IDLE.
  - Requests from other ports are held off until return to IDLE.
- Minimum latency, s_req rise to m_req rise: 1 edge.
- Minimum latency, m_ack sampled to s_ack rise: 1 edge.
- Minimum per-transfer cycle: IDLE->FWD->ACK->IDLE = 3 edges, plus the downstream ack delay.
- Fairness: after g is served, g has lowest priority. With all ports requesting continuously, grants go 0,1,2,3,0,...
- A requester dropping s_req while in FWD (protocol violation): the transfer still completes, and ACK exits on the first edge.
- Reset asserted mid-transfer: immediate return to the reset values. An in-flight transfer is lost, with no ack to either side.
- NUM_REQ=1: degenerates to a registered pass-through; the rr pointer stays 0.

Optional Feature:
- IFRA_ARB_TIMEOUT_EN defined:
  - A counter clears on entry to FWD and increments each FWD cycle.
  - If it reaches TIMEOUT_CYC without m_ack: m_req<=0, timeout_err<=1 (sticky until reset), s_ack[g]<=1, state->ACK. This releases the requester so the bench does not hang.
- Undefined: no counter; FWD waits indefinitely for m_ack; timeout_err is constant 0.

Test Plan:
- Single request: s_req=4'b0001, s_din[0]=8'hA5, sink acks 2 cycles after m_req -> m_dout=8'hA5, grant_id=0, s_ack[0] high until s_req[0] drops, busy low again 1 edge later.
- Round-robin: all four ports request continuously with data 8'h10,8'h11,8'h12,8'h13 -> sink receives 10,11,12,13,10 in order, with s_ack one-hot each time.
- Pointer wrap: serve port 3, then s_req=4'b1001 -> port 0 granted before port 3.
- Data stability: change s_din[g] to 8'hFF while in FWD -> m_dout keeps the originally captured value.
- Reset mid-transfer: pulse rst_n low while in FWD -> m_req=0, s_ack=0, grant_id=0 immediately. A subsequent port-2 request is granted normally.
- Timeout (macro defined, TIMEOUT_CYC=8, sink never acks): m_req drops 8 cycles after rising, timeout_err=1, s_ack[g]=1 until s_req[g] drops.
